// File: rtl/sseg_controller.sv
// rtl/sseg_controller.sv - bus-mapped four-digit multiplexed seven-segment display controller
// Optional build macro SSEG_BLANK_LEADING_ZEROS_EN blanks leading zero digits above digit 0.
module sseg_controller #(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_2008,
  parameter int          REFRESH_DIV = 100000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [3:0]  be,
  output logic        ack,
  output logic [31:0] rdata,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp
);

  localparam int DIV_W = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;

  logic [23:0]      ctrl;
  logic [DIV_W-1:0] div_cnt;
  logic [1:0]       idx;
  logic             hit;
  logic             wrap;
  logic [3:0]       nib;
  logic             digit_on;
  logic             lead_zero;
  logic [3:0]       an_nxt;
  logic [6:0]       seg_nxt;
  logic             dp_nxt;
  logic [3:0]       en_vec;
  logic [3:0]       dp_vec;

  // Byte 3 of the bus word and the byte offset within the word are never used.
  logic unused_bits;
  assign unused_bits = &{1'b0, be[3], addr[1:0], wdata[31:24]};

  assign hit    = req && (addr[31:2] == BASE_ADDR[31:2]);
  assign wrap   = (div_cnt == DIV_W'(REFRESH_DIV - 1));
  assign en_vec = ctrl[23:20];
  assign dp_vec = ctrl[19:16];

  function automatic logic [6:0] hex_decode(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

  always_comb begin
    nib = 4'h0;
    case (idx)
      2'd0: nib = ctrl[3:0];
      2'd1: nib = ctrl[7:4];
      2'd2: nib = ctrl[11:8];
      default: nib = ctrl[15:12];
    endcase
  end

`ifdef SSEG_BLANK_LEADING_ZEROS_EN
  // A digit is a leading zero when it and every more significant nibble are zero.
  always_comb begin
    lead_zero = 1'b0;
    case (idx)
      2'd1: lead_zero = (ctrl[15:4] == 12'h000);
      2'd2: lead_zero = (ctrl[15:8] == 8'h00);
      2'd3: lead_zero = (ctrl[15:12] == 4'h0);
      default: lead_zero = 1'b0;
    endcase
  end
`else
  assign lead_zero = 1'b0;
`endif

  always_comb begin
    digit_on = en_vec[idx] && !lead_zero;
    an_nxt   = digit_on ? ~(4'b0001 << idx) : 4'hF;
    seg_nxt  = digit_on ? hex_decode(nib) : 7'h7F;
    dp_nxt   = ~(digit_on && dp_vec[idx]);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ctrl    <= '0;
      div_cnt <= '0;
      idx     <= 2'd0;
      ack     <= 1'b0;
      rdata   <= '0;
      an      <= 4'hF;
      seg     <= 7'h7F;
      dp      <= 1'b1;
    end else begin
      ack   <= hit;
      rdata <= (hit && !we) ? {8'h00, ctrl} : 32'h0;
      if (hit && we) begin
        for (int k = 0; k < 3; k++) begin
          if (be[k]) ctrl[8*k +: 8] <= wdata[8*k +: 8];
        end
      end
      if (wrap) begin
        div_cnt <= '0;
        idx     <= idx + 2'd1;
      end else begin
        div_cnt <= div_cnt + DIV_W'(1);
      end
      an  <= an_nxt;
      seg <= seg_nxt;
      dp  <= dp_nxt;
    end
  end

endmodule

// File: tb/tb_sseg_controller.sv
// tb/tb_sseg_controller.sv - self-checking bench for sseg_controller with REFRESH_DIV=4
module tb_sseg_controller;

  logic        clk = 1'b0;
  logic        rst;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  be;
  logic        ack;
  logic [31:0] rdata;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;

  int checks = 0;
  int errors = 0;
  int cyc;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic        exp_ack;
    logic [31:0] exp_rdata;
  } vec_t;

  typedef struct {
    logic        ack;
    logic        chk_rd;
    logic [31:0] rd;
  } exp_t;

  vec_t       vecs[13];
  exp_t       sbq[$];
  exp_t       mon_e;
  logic [6:0] dec_tab[16];

  sseg_controller #(.BASE_ADDR(32'h0000_2008), .REFRESH_DIV(4)) dut (
    .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .wdata(wdata), .be(be),
    .ack(ack), .rdata(rdata), .an(an), .seg(seg), .dp(dp)
  );

  always #5 clk = ~clk;

  always @(posedge clk or posedge rst) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  // Bus monitor: every transaction sampled on an edge is answered one edge later.
  always @(posedge clk) begin
    if (req && !rst) begin
      #1;
      if (sbq.size() == 0) begin
        errors++;
        $display("FAIL sb_underflow: transaction with no expected entry");
      end else begin
        mon_e = sbq.pop_front();
        checks++;
        if (ack !== mon_e.ack) begin
          errors++;
          $display("FAIL bus_ack: got %0b want %0b", ack, mon_e.ack);
        end
        if (mon_e.chk_rd) begin
          checks++;
          if (rdata !== mon_e.rd) begin
            errors++;
            $display("FAIL bus_rdata: got %08h want %08h", rdata, mon_e.rd);
          end
        end
      end
    end
  end

  task automatic drive(input logic w, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] b, input logic e_ack, input logic [31:0] e_rd);
    exp_t e;
    @(negedge clk);
    req = 1'b1; we = w; addr = a; wdata = d; be = b;
    e.ack    = e_ack;
    e.chk_rd = !w || !e_ack;
    e.rd     = e_ack ? e_rd : 32'h0;
    sbq.push_back(e);
  endtask

  task automatic idle();
    @(negedge clk);
    req = 1'b0; we = 1'b0; addr = 32'h0; wdata = 32'h0; be = 4'h0;
  endtask

  task automatic drain(input string name);
    repeat (2) @(negedge clk);
    checks++;
    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL %s_drain: %0d responses outstanding, want 0", name, sbq.size());
      sbq.delete();
    end
  endtask

  task automatic write_ctrl(input logic [31:0] v);
    drive(1'b1, 32'h2008, v, 4'hF, 1'b1, 32'h0);
    idle();
    drain("write_ctrl");
  endtask

  function automatic logic [11:0] exp_disp(input logic [23:0] c, input int i);
    logic       on;
    logic [3:0] a;
    logic [6:0] s;
    logic       p;
    on = c[20+i];
`ifdef SSEG_BLANK_LEADING_ZEROS_EN
    if (i > 0 && ((c[15:0] >> (4*i)) == 16'h0)) on = 1'b0;
`endif
    a = on ? ~(4'b0001 << i) : 4'hF;
    s = on ? dec_tab[c[4*i +: 4]] : 7'h7F;
    p = ~(on & c[16+i]);
    return {a, s, p};
  endfunction

  // The scan phase is derived from edges counted since reset release.
  task automatic check_scan(input string name, input logic [23:0] c, input int ncyc);
    logic [11:0] e;
    for (int n = 0; n < ncyc; n++) begin
      @(negedge clk);
      e = exp_disp(c, ((cyc - 1) / 4) % 4);
      checks++;
      if ({an, seg, dp} !== e) begin
        errors++;
        $display("FAIL %s_scan cyc %0d: an/seg/dp got %h/%h/%b want %h/%h/%b",
                 name, cyc, an, seg, dp, e[11:8], e[7:1], e[0]);
      end
    end
  endtask

  task automatic check_reset_outputs(input string name);
    checks++;
    if (an !== 4'hF || seg !== 7'h7F || dp !== 1'b1 || ack !== 1'b0 || rdata !== 32'h0) begin
      errors++;
      $display("FAIL %s: an/seg/dp/ack/rdata got %h/%h/%b/%b/%08h want f/7f/1/0/00000000",
               name, an, seg, dp, ack, rdata);
    end
  endtask

  initial begin
    dec_tab = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    vecs[0]  = '{1'b1, 32'h0000_2008, 32'hABF5_1234, 4'hF, 1'b1, 32'h0};
    vecs[1]  = '{1'b0, 32'h0000_2008, 32'h0,         4'h0, 1'b1, 32'h00F5_1234};
    vecs[2]  = '{1'b1, 32'h0000_2008, 32'hFFFF_5678, 4'h3, 1'b1, 32'h0};
    vecs[3]  = '{1'b0, 32'h0000_2008, 32'h0,         4'h0, 1'b1, 32'h00F5_5678};
    vecs[4]  = '{1'b1, 32'h0000_2008, 32'h1111_1111, 4'h0, 1'b1, 32'h0};
    vecs[5]  = '{1'b0, 32'h0000_2008, 32'h0,         4'h0, 1'b1, 32'h00F5_5678};
    vecs[6]  = '{1'b1, 32'h0000_2004, 32'h0000_0000, 4'hF, 1'b0, 32'h0};
    vecs[7]  = '{1'b0, 32'h0000_2004, 32'h0,         4'h0, 1'b0, 32'h0};
    vecs[8]  = '{1'b1, 32'h0000_200C, 32'h0000_0000, 4'hF, 1'b0, 32'h0};
    vecs[9]  = '{1'b0, 32'h0000_200C, 32'h0,         4'h0, 1'b0, 32'h0};
    vecs[10] = '{1'b0, 32'h0000_2008, 32'h0,         4'h0, 1'b1, 32'h00F5_5678};
    vecs[11] = '{1'b1, 32'h0000_200B, 32'h00F5_1234, 4'hF, 1'b1, 32'h0};
    vecs[12] = '{1'b0, 32'h0000_200A, 32'h0,         4'h0, 1'b1, 32'h00F5_1234};

    rst = 1'b1; req = 1'b0; we = 1'b0; addr = 32'h0; wdata = 32'h0; be = 4'h0;
    repeat (2) @(negedge clk);
    check_reset_outputs("reset_initial");
    rst = 1'b0;

    // Back-to-back bus traffic: writes, byte enables, decode misses, offset hits.
    for (int i = 0; i < 13; i++)
      drive(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].be, vecs[i].exp_ack, vecs[i].exp_rdata);
    idle();
    drain("table");

    repeat (2) @(negedge clk);
    check_scan("digits", 24'hF5_1234, 20);

    write_ctrl(32'h00E0_0000);
    check_scan("enable", 24'hE0_0000, 16);

    write_ctrl(32'h00F0_0007);
    check_scan("leadzero", 24'hF0_0007, 16);

    // Asynchronous reset landing mid-scan and mid-cycle.
    write_ctrl(32'h00F5_1234);
    repeat (5) @(negedge clk);
    @(posedge clk);
    #3 rst = 1'b1;
    #1 check_reset_outputs("reset_async");
    @(negedge clk);
    rst = 1'b0;
    drive(1'b0, 32'h0000_2008, 32'h0, 4'h0, 1'b1, 32'h0);
    idle();
    drain("post_reset");
    check_scan("post_reset", 24'h0, 4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: bench did not complete within 20000 time units");
    $fatal(1);
  end

endmodule
